param_timebomb: RTL and testbench

PARAM_TIMEBOMB -- requirements
Module: param_timebomb

---
 rtl/timebomb_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 36 +++
 rtl/param_timebomb.sv | 106 ++++++++++
 tb/tb_param_timebomb.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/timebomb_pkg.sv
// Shared definitions for the countdown timebomb: state encodings and state width.
package timebomb_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_BOOM  = 3'd3,
    ST_SAFE  = 3'd4
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by DIV; tick fires on the enabled cycle that completes a period.
module tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] cnt_q, cnt_d;

  // With DIV=1 the counter is parked at zero and every enabled cycle ticks.
  assign tick = enable && ((DIV == 1) || (cnt_q == PW'(DIV - 1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || (DIV == 1) || tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_timebomb.sv
// Parameterised countdown timebomb with pause, defuse code and limited wrong-code attempts.
module param_timebomb
  import timebomb_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               PRESET    = 15,
  parameter int               DIV       = 1,
  parameter logic [WIDTH-1:0] CODE      = '0,
  parameter int               MAX_TRIES = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stop,
  input  logic               Defuse,
  input  logic [WIDTH-1:0]   Code_In,
  output logic [WIDTH-1:0]   Counter_Out,
  output logic [STATE_W-1:0] State_Out,
  output logic               blow_up,
  output logic               defused
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic             pre_en, pre_clr, tick;

  // Prescaler only advances in RUN on cycles not claimed by Defuse or Stop.
  assign pre_en  = (state_q == ST_RUN) && !Defuse && !Stop;
  assign pre_clr = (state_q == ST_IDLE);

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk_i (Clock),
    .rst_ni(Reset),
    .enable(pre_en),
    .clear (pre_clr),
    .tick  (tick)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      count_q <= WIDTH'(PRESET);
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tries_q <= tries_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tries_d = tries_q;
    unique case (state_q)
      ST_IDLE: begin
        count_d = WIDTH'(PRESET);
        tries_d = '0;
        if (Start) state_d = ST_RUN;
      end
      ST_RUN, ST_PAUSE: begin
        if (Defuse) begin
          if (Code_In == CODE) begin
            state_d = ST_SAFE;
          end else begin
            tries_d = tries_q + TW'(1);
            if (tries_d == TW'(MAX_TRIES)) begin
              state_d = ST_BOOM;
              count_d = '0;
            end
          end
        end else if (state_q == ST_RUN) begin
          if (Stop) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) state_d = ST_BOOM;
          end
        end else if (Start && !Stop) begin
          state_d = ST_RUN;
        end
      end
      ST_BOOM, ST_SAFE: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = WIDTH'(PRESET);
        tries_d = '0;
      end
    endcase
  end

  always_comb begin
    Counter_Out = count_q;
    State_Out   = state_q;
    blow_up     = (state_q == ST_BOOM);
    defused     = (state_q == ST_SAFE);
  end

endmodule

// File: tb/tb_param_timebomb.sv
// Cycle-accurate checks of the timebomb against hand-derived expected count/state per edge.
module tb_param_timebomb;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Stop = 1'b0;
  logic       Defuse = 1'b0;
  logic [3:0] Code_In = 4'h0;
  logic [3:0] Counter_Out;
  logic [2:0] State_Out;
  logic       blow_up;
  logic       defused;

  param_timebomb #(
    .WIDTH(4), .PRESET(5), .DIV(2), .CODE(4'hA), .MAX_TRIES(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .Defuse(Defuse),
    .Code_In(Code_In), .Counter_Out(Counter_Out), .State_Out(State_Out),
    .blow_up(blow_up), .defused(defused)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       defuse;
    logic [3:0] code;
    logic [3:0] ecnt;
    logic [2:0] est;
  } vec_t;

  typedef struct {
    logic [3:0] cnt;
    logic [2:0] st;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic r, logic s, logic p, logic d, logic [3:0] c,
                              logic [3:0] ec, logic [2:0] es);
    vec_t v;
    v.rst_n = r; v.start = s; v.stop = p; v.defuse = d; v.code = c;
    v.ecnt = ec; v.est = es;
    return v;
  endfunction

  task automatic check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, queue its expected outcome, and check after the edge.
  task automatic step(vec_t v);
    exp_t e;
    exp_t got;
    @(negedge Clock);
    Reset = v.rst_n; Start = v.start; Stop = v.stop; Defuse = v.defuse; Code_In = v.code;
    e.cnt = v.ecnt; e.st = v.est;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      got = sb.pop_front();
      check("Counter_Out", int'(Counter_Out), int'(got.cnt));
      check("State_Out", int'(State_Out), int'(got.st));
      check("blow_up", int'(blow_up), int'(got.st == 3'd3));
      check("defused", int'(defused), int'(got.st == 3'd4));
    end
  endtask

  task automatic n(logic [3:0] ec, logic [2:0] es);
    step(mk(1, 0, 0, 0, 4'h0, ec, es));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, ignored inputs in IDLE, plain countdown to BOOM, BOOM terminal.
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 5, 0));
    tbl.push_back(mk(1, 0, 1, 1, 4'hA, 5, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 5, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 5, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 3, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 3, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 2, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 2, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 3));
    tbl.push_back(mk(1, 1, 0, 1, 4'hA, 0, 3));
    // Pause at count 3 for four Stop cycles (last one with Start too), then resume.
    tbl.push_back(mk(0, 1, 1, 1, 4'hA, 5, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 5, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 5, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 3, 1));
    tbl.push_back(mk(1, 0, 1, 0, 4'h0, 3, 2));
    tbl.push_back(mk(1, 0, 1, 0, 4'h0, 3, 2));
    tbl.push_back(mk(1, 0, 1, 0, 4'h0, 3, 2));
    tbl.push_back(mk(1, 1, 1, 0, 4'h0, 3, 2));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 3, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 3, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 2, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 2, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 3));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Correct code at count 2: SAFE, count frozen, Start ignored afterwards.
    step(mk(0, 0, 0, 0, 4'h0, 5, 0));
    step(mk(1, 1, 0, 0, 4'h0, 5, 1));
    n(5, 1); n(4, 1); n(4, 1); n(3, 1); n(3, 1); n(2, 1);
    step(mk(1, 0, 0, 1, 4'hA, 2, 4));
    step(mk(1, 1, 0, 0, 4'h0, 2, 4));
    n(2, 4);

    // Two wrong codes in RUN: first suppresses a tick, second forces BOOM with count 0.
    step(mk(0, 0, 0, 0, 4'h0, 5, 0));
    step(mk(1, 1, 0, 0, 4'h0, 5, 1));
    n(5, 1);
    step(mk(1, 0, 0, 1, 4'h3, 5, 1));
    n(4, 1); n(4, 1);
    step(mk(1, 0, 0, 1, 4'h7, 0, 3));
    step(mk(1, 1, 0, 1, 4'hA, 0, 3));

    // Correct code on the tick that would reach 0: SAFE with count 1.
    step(mk(0, 0, 0, 0, 4'h0, 5, 0));
    step(mk(1, 1, 0, 0, 4'h0, 5, 1));
    n(5, 1); n(4, 1); n(4, 1); n(3, 1); n(3, 1); n(2, 1); n(2, 1); n(1, 1); n(1, 1);
    step(mk(1, 0, 0, 1, 4'hA, 1, 4));
    n(1, 4);

    // Reset mid-RUN at count 3, then a fresh countdown with the original timing.
    step(mk(0, 0, 0, 0, 4'h0, 5, 0));
    step(mk(1, 1, 0, 0, 4'h0, 5, 1));
    n(5, 1); n(4, 1); n(4, 1); n(3, 1);
    step(mk(0, 1, 0, 0, 4'h0, 5, 0));
    step(mk(1, 1, 0, 0, 4'h0, 5, 1));
    n(5, 1); n(4, 1); n(4, 1); n(3, 1); n(3, 1); n(2, 1); n(2, 1); n(1, 1); n(1, 1);
    n(0, 3);

    // Reset from PAUSE.
    step(mk(1, 1, 0, 0, 4'h0, 0, 3));
    step(mk(0, 0, 0, 0, 4'h0, 5, 0));
    step(mk(1, 1, 0, 0, 4'h0, 5, 1));
    step(mk(1, 0, 1, 0, 4'h0, 5, 2));
    step(mk(0, 1, 0, 0, 4'h0, 5, 0));

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
